// File: rtl/sprite_plotter.sv
// sprite_plotter: multi-sprite erase/draw frame renderer feeding a vga_adapter pixel port
module sprite_plotter #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int BG_COLOUR = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [NUM_SPRITES*X_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
  input  logic [NUM_SPRITES-1:0] sprite_en,
  input  logic [NUM_SPRITES*SPRITE_W*SPRITE_H-1:0] sprite_mask,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [COLOUR_W-1:0] colour,
  output logic plot,
  output logic busy,
  output logic done
);
  localparam int PIX = SPRITE_W * SPRITE_H;
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
  localparam int PW = PIX > 1 ? $clog2(PIX) : 1;
  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [PW-1:0] pix, pix_n;
  logic [X_W-1:0] sx [NUM_SPRITES];
  logic [Y_W-1:0] sy [NUM_SPRITES];
  logic [COLOUR_W-1:0] sc [NUM_SPRITES];
  logic [PIX-1:0] sm [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] se, drawn;
  logic [X_W-1:0] old_x [NUM_SPRITES];
  logic [Y_W-1:0] old_y [NUM_SPRITES];
  logic act, last, act_n, pl;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic [COLOUR_W-1:0] pc;
  // Sequencer: a sprite with nothing to do (not drawn / not enabled) costs one skip cycle
  always_comb begin
    act = state == ERASE ? drawn[idx] : se[idx];
    last = !act || pix == PW'(PIX - 1);
    state_n = state;
    idx_n = idx;
    pix_n = pix;
    if (state == IDLE && start) state_n = LATCH;
    else if (state == LATCH) state_n = ERASE;
    else if (state == DONE) state_n = IDLE;
    else if (state == ERASE || state == DRAW) begin
      pix_n = last ? '0 : pix + 1'b1;
      idx_n = !last ? idx : idx == IW'(NUM_SPRITES - 1) ? '0 : idx + 1'b1;
      if (last && idx == IW'(NUM_SPRITES - 1)) state_n = state == ERASE ? DRAW : DONE;
    end
  end
  // Pixel for the upcoming cycle, so the registered outputs line up with the state they describe
  always_comb begin
    act_n = state_n == ERASE ? drawn[idx_n] : se[idx_n];
    px = {1'b0, state_n == ERASE ? old_x[idx_n] : sx[idx_n]} + (X_W + 1)'(pix_n % SPRITE_W);
    py = {1'b0, state_n == ERASE ? old_y[idx_n] : sy[idx_n]} + (Y_W + 1)'(pix_n / SPRITE_W);
    pc = state_n == ERASE ? COLOUR_W'(BG_COLOUR) : sc[idx_n];
    pl = act_n && (state_n == ERASE || (state_n == DRAW && sm[idx_n][pix_n]))
      && px < (X_W + 1)'(SCREEN_W) && py < (Y_W + 1)'(SCREEN_H);
  end
  // State, outputs and per-sprite drawn bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      pix <= '0;
      drawn <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
      end
    end else begin
      state <= state_n;
      idx <= idx_n;
      pix <= pix_n;
      plot <= pl;
      busy <= state_n inside {LATCH, ERASE, DRAW};
      done <= state_n == DONE;
      if (state_n == ERASE || state_n == DRAW) begin
        x <= px[X_W-1:0];
        y <= py[Y_W-1:0];
        colour <= pc;
      end
      if (state == DRAW && last) begin
        drawn[idx] <= se[idx];
        old_x[idx] <= sx[idx];
        old_y[idx] <= sy[idx];
      end
    end
  end
  // Frame snapshot so input changes mid-frame cannot tear the picture
  always_ff @(posedge clk) begin
    if (state == LATCH) begin
      se <= sprite_en;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i] <= sprite_x[i*X_W +: X_W];
        sy[i] <= sprite_y[i*Y_W +: Y_W];
        sc[i] <= sprite_colour[i*COLOUR_W +: COLOUR_W];
        sm[i] <= sprite_mask[i*PIX +: PIX];
      end
    end
  end
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench comparing plotted pixels and frame lengths against a pixel-list model
module tb_sprite_plotter;
  localparam int N = 2, W = 8, H = 8, XW = 9, YW = 8, CW = 3;
  logic clk = 0, reset = 1, start = 0;
  logic [N*XW-1:0] sprite_x = '0;
  logic [N*YW-1:0] sprite_y = '0;
  logic [N*CW-1:0] sprite_colour = '0;
  logic [N-1:0] sprite_en = '0;
  logic [N*W*H-1:0] sprite_mask = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic plot, busy, done;
  typedef struct {int x; int y; int c;} px_t;
  px_t pix_q[$];
  int len_q[$];
  px_t e;
  int checks = 0, errors = 0, bcnt = 0;
  bit m_drawn[N];
  int m_ox[N], m_oy[N];
  sprite_plotter #(.NUM_SPRITES(N), .SPRITE_W(W), .SPRITE_H(H), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_colour(sprite_colour), .sprite_en(sprite_en), .sprite_mask(sprite_mask),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_spr(input int i, input int sx, input int sy, input int c, input bit en, input logic [63:0] m);
    sprite_x[i*XW +: XW] = XW'(sx);
    sprite_y[i*YW +: YW] = YW'(sy);
    sprite_colour[i*CW +: CW] = CW'(c);
    sprite_en[i] = en;
    sprite_mask[i*W*H +: W*H] = m;
  endtask
  task automatic scramble();
    for (int i = 0; i < N; i++)
      set_spr(i, $urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 7), 1'($urandom), {$urandom, $urandom});
  endtask
  // Reference: the list of pixels that must be written this frame, in order, and the frame length
  task automatic model_frame();
    int len = 2;
    for (int i = 0; i < N; i++) begin
      if (m_drawn[i]) begin
        len += W * H;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            if (m_ox[i] + c < 320 && m_oy[i] + r < 240) pix_q.push_back('{m_ox[i] + c, m_oy[i] + r, 0});
      end else len++;
    end
    for (int i = 0; i < N; i++) begin
      if (sprite_en[i]) begin
        int bx = int'(sprite_x[i*XW +: XW]);
        int by = int'(sprite_y[i*YW +: YW]);
        len += W * H;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            if (sprite_mask[i*W*H + r*W + c] && bx + c < 320 && by + r < 240)
              pix_q.push_back('{bx + c, by + r, int'(sprite_colour[i*CW +: CW])});
        m_drawn[i] = 1;
        m_ox[i] = bx;
        m_oy[i] = by;
      end else begin
        len++;
        m_drawn[i] = 0;
      end
    end
    len_q.push_back(len);
  endtask
  task automatic frame(input bit scr, input bit extra, input bit dstart);
    int k;
    model_frame();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("busy_rise", busy, 1);
    repeat (3) @(negedge clk);
    if (scr) scramble();
    if (extra) begin
      start = 1;
      @(negedge clk) start = 0;
    end
    for (k = 0; k < 2000 && !done; k++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout after %0d cycles", k);
    end
    if (dstart) begin
      start = 1;
      @(negedge clk) start = 0;
      chk("start_in_done_ignored", busy, 0);
    end else @(negedge clk);
  endtask
  // Monitor: every plot strobe consumes one expected pixel; every done consumes one frame record
  always @(negedge clk) begin
    if (reset) bcnt = 0;
    else begin
      if (plot) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_extra got (%0d,%0d) expected none", x, y);
        end else begin
          e = pix_q.pop_front();
          chk("pixel", {x, y, colour}, {XW'(e.x), YW'(e.y), CW'(e.c)});
        end
      end
      if (busy) bcnt++;
      if (done) begin
        if (len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra got done expected none");
        end else begin
          chk("frame_len", bcnt + 1, len_q.pop_front());
          chk("pix_left", pix_q.size(), 0);
        end
        bcnt = 0;
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {x, y, colour, plot, busy, done}, 0);
    reset = 0;
    @(negedge clk);
    set_spr(0, 10, 20, 4, 1, '1);
    set_spr(1, 100, 50, 2, 1, '1);
    frame(0, 0, 0);
    set_spr(0, 12, 20, 4, 1, '1);
    frame(0, 0, 0);
    set_spr(0, 10, 20, 4, 1, 64'h1);
    frame(0, 0, 0);
    set_spr(0, 316, 236, 5, 1, '1);
    frame(0, 0, 1);
    sprite_en[1] = 0;
    frame(0, 1, 0);
    frame(0, 0, 0);
    sprite_en[1] = 1;
    frame(0, 0, 0);
    model_frame();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (20) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    repeat (180) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_reset", {x, y, colour, plot, busy, done}, 0);
    pix_q.delete();
    len_q.delete();
    m_drawn = '{default: 0};
    reset = 0;
    frame(0, 0, 0);
    for (int f = 0; f < 20; f++) begin
      scramble();
      frame(1, f % 3 == 0, f % 5 == 0);
    end
    repeat (5) @(negedge clk);
    chk("len_q_empty", len_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
